ber_fault_inject: RTL and testbench
===================================

BER_FAULT_INJECT -- requirements
Module: ber_fault_inject

Interface
REQ-001 Parameter DATA_WIDTH, default 64, data and mask width; SHALL be 64 to match the BER mask generator.
REQ-002 Parameter CNT_WIDTH, default 32, width of the statistics counters.
REQ-003 Parameter SKIP_WIDTH, default 16, width of the warm-up beat count.
REQ-004 clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 cfg_en_i  in  1  injection enable.
REQ-007 cfg_skip_i  in  SKIP_WIDTH  beats to pass clean after enable before injection starts.
REQ-008 cnt_clear_i  in  1  clears the statistics counters.
REQ-009 in_valid_i / in_ready_o / in_data_i  in/out/in  1/1/DATA_WIDTH  upstream read-data stream from the cache SRAM.
REQ-010 out_valid_o / out_ready_i / out_data_o  out/in/out  1/1/DATA_WIDTH  corrupted stream to the cache controller.
REQ-011 out_flip_o  out  1  the beat held in out_data_o had at least one bit flipped.
REQ-012 mask_en_o  out  1  advance strobe driven to the mask generator's en_i.
REQ-013 mask_i  in  DATA_WIDTH  combinational mask from the mask generator.
REQ-014 flip_cnt_o  out  CNT_WIDTH  total bits flipped, saturating.
REQ-015 beat_cnt_o  out  CNT_WIDTH  beats with at least one flip, saturating.
REQ-016 state_o  out  2  current FSM state (OFF=0, WARM=1, ON=2).

Function
REQ-017 Pipeline: one output register stage.
- in_ready_o SHALL equal !out_valid_o || out_ready_i.
- accept = in_valid_i && in_ready_o.
REQ-018 On accept, out_valid_o SHALL be 1 the next cycle. Otherwise, out_valid_o SHALL clear when out_ready_i=1, and hold while out_ready_i=0.
REQ-019 On accept, out_data_o SHALL load in_data_i XOR applied_mask, where applied_mask = mask_i if state==ON, else 0.
- out_flip_o SHALL load (applied_mask != 0).
- Latency: exactly 1 cycle.
REQ-020 While out_valid_o=1 and out_ready_i=0, out_data_o and out_flip_o SHALL remain stable.
REQ-021 mask_en_o SHALL equal accept && state==ON, so the generator advances exactly once per injected beat and never during stalls.
REQ-022 FSM transitions:
- OFF -> WARM when cfg_en_i=1 and cfg_skip_i!=0; load skip counter with cfg_skip_i.
- OFF -> ON when cfg_en_i=1 and cfg_skip_i==0.
REQ-023 WARM: the skip counter SHALL decrement by 1 per accept. Accepted beats pass unmodified. On the accept that brings the counter from 1 to 0, next state SHALL be ON.
REQ-024 Any state -> OFF when cfg_en_i=0; this SHALL take priority over all other transitions.
REQ-025 A state change SHALL affect only beats accepted after the change; the beat accepted in the transition cycle uses the pre-transition state.
REQ-026 On each accept in ON:
- flip_cnt_o += popcount(applied_mask).
- beat_cnt_o += 1 if applied_mask != 0.
- Both SHALL saturate at 2^CNT_WIDTH-1 and never wrap.
REQ-027 cnt_clear_i=1 SHALL zero both counters next cycle and discard that cycle's increment (clear wins).
REQ-028 Popcount SHALL be computed at full precision (7 bits for 64) and zero-extended before the saturating add.

Reset
REQ-029 With rst_i=1 at a clock edge, the following SHALL be set regardless of any other input:
- state=OFF, skip counter=0
- out_valid_o=0, out_data_o=0, out_flip_o=0
- flip_cnt_o=0, beat_cnt_o=0
REQ-030 During reset, in_ready_o SHALL follow REQ-017 from the reset register values and mask_en_o SHALL be 0. A beat held mid-stall SHALL be dropped by reset.

Verification
REQ-031 cfg_en_i=0, mask_i=all-ones, send 0x0123456789ABCDEF -> out_data_o identical, out_flip_o=0, mask_en_o never 1, counters 0.
REQ-032 cfg_en_i=1, cfg_skip_i=0, mask_i=0x0000_0000_0000_00FF, send 0x0 then 0xFFFF_FFFF_FFFF_FFFF -> outputs 0xFF and 0xFFFF_FFFF_FFFF_FF00; flip_cnt=16, beat_cnt=2; mask_en_o pulsed twice.
REQ-033 cfg_skip_i=3, cfg_en_i=1, mask_i=0x1, send 5 beats of 0x0 -> first 3 outputs 0x0, last 2 outputs 0x1; state_o sequence 1,1,1,2; beat_cnt=2.
REQ-034 Hold out_ready_i=0 for 4 cycles with in_valid_i=1 in ON -> in_ready_o=0, out_data_o stable, mask_en_o=0 throughout; one accept after release.
REQ-035 Preload flip_cnt to 2^CNT_WIDTH-3, inject mask 0xF -> flip_cnt=2^CNT_WIDTH-1. Assert cnt_clear_i on an injecting accept -> both counters 0.
REQ-036 Assert rst_i while out_valid_o=1 and state=ON -> next cycle out_valid_o=0, state_o=0, counters 0.

Source files
------------

// File: rtl/ber_fault_inject.sv
// ber_fault_inject: bit-error fault injector between the cache SRAM read port and the cache
// controller. A single output register stage XORs an externally generated mask into accepted
// beats once the injector is enabled and a programmable number of clean warm-up beats has
// passed. Counts flipped bits and corrupted beats with saturating counters.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cfg_en_i, cfg_skip_i         injection enable, clean warm-up beats after enable
//   cnt_clear_i                  zero the statistics counters (wins over increments)
//   in_valid_i/in_ready_o/in_data_i     upstream stream
//   out_valid_o/out_ready_i/out_data_o  corrupted downstream stream
//   out_flip_o                   beat in out_data_o had at least one bit flipped
//   mask_en_o, mask_i            advance strobe to / mask from the BER mask generator
//   flip_cnt_o, beat_cnt_o       flipped-bit and corrupted-beat counters
//   state_o                      FSM state (0 off, 1 warm-up, 2 injecting)
module ber_fault_inject #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned SKIP_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_en_i,
    input  logic [SKIP_WIDTH-1:0] cfg_skip_i,
    input  logic                  cnt_clear_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_flip_o,
    output logic                  mask_en_o,
    input  logic [DATA_WIDTH-1:0] mask_i,
    output logic [CNT_WIDTH-1:0]  flip_cnt_o,
    output logic [CNT_WIDTH-1:0]  beat_cnt_o,
    output logic [1:0]            state_o
);

    localparam int unsigned PopWidth = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        StOff  = 2'd0,
        StWarm = 2'd1,
        StOn   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [SKIP_WIDTH-1:0] skip_q, skip_d;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_flip_q;

    logic [CNT_WIDTH-1:0]  flip_cnt_q, flip_cnt_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH:0]    flip_sum, beat_sum;

    logic                  accept;
    logic                  inject;
    logic [DATA_WIDTH-1:0] applied_mask;
    logic [PopWidth-1:0]   mask_pop;

    assign in_ready_o   = !out_valid_q || out_ready_i;
    assign accept       = in_valid_i && in_ready_o;
    // Injection uses the registered state, so a beat accepted during a transition sees the
    // pre-transition mode.
    assign inject       = (state_q == StOn);
    assign applied_mask = inject ? mask_i : '0;
    // Generator advances once per injected beat; never during reset or stalls.
    assign mask_en_o    = accept && inject && !rst_i;

    // Full-precision popcount of the applied mask.
    always_comb begin
        mask_pop = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            mask_pop = mask_pop + PopWidth'(applied_mask[i]);
        end
    end

    // Saturating statistics counters; one extra bit catches the carry-out.
    always_comb begin
        flip_sum   = {1'b0, flip_cnt_q} + (CNT_WIDTH + 1)'(mask_pop);
        beat_sum   = {1'b0, beat_cnt_q} + (CNT_WIDTH + 1)'(applied_mask != '0);
        flip_cnt_d = flip_cnt_q;
        beat_cnt_d = beat_cnt_q;
        if (cnt_clear_i) begin
            flip_cnt_d = '0;
            beat_cnt_d = '0;
        end else if (accept && inject) begin
            flip_cnt_d = flip_sum[CNT_WIDTH] ? '1 : flip_sum[CNT_WIDTH-1:0];
            beat_cnt_d = beat_sum[CNT_WIDTH] ? '1 : beat_sum[CNT_WIDTH-1:0];
        end
    end

    // Mode FSM; disable overrides everything.
    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        if (!cfg_en_i) begin
            state_d = StOff;
        end else begin
            unique case (state_q)
                StOff: begin
                    if (cfg_skip_i != '0) begin
                        state_d = StWarm;
                        skip_d  = cfg_skip_i;
                    end else begin
                        state_d = StOn;
                    end
                end
                StWarm: begin
                    if (accept) begin
                        skip_d = skip_q - SKIP_WIDTH'(1);
                        // <= guards against a zero count ever lingering in warm-up.
                        if (skip_q <= SKIP_WIDTH'(1)) begin
                            state_d = StOn;
                            skip_d  = '0;
                        end
                    end
                end
                StOn: begin
                    state_d = StOn;
                end
                default: begin
                    state_d = StOff;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StOff;
            skip_q     <= '0;
            flip_cnt_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            skip_q     <= skip_d;
            flip_cnt_q <= flip_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Output register stage; data and flip hold while stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flip_q  <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= in_data_i ^ applied_mask;
            out_flip_q  <= (applied_mask != '0);
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_flip_o  = out_flip_q;
    assign flip_cnt_o  = flip_cnt_q;
    assign beat_cnt_o  = beat_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_ber_fault_inject.sv
// Testbench for ber_fault_inject. Counters are built 8 bits wide so saturation is reachable
// in a short run. Expected values come from a beat-level model: after enable, beat k
// (0-based) is injected when k >= skip; counters accumulate popcounts with min() clamping.
module tb_ber_fault_inject;

    localparam int unsigned DW = 64;
    localparam int unsigned CW = 8;
    localparam int unsigned SW = 16;
    localparam longint      CMAX = (longint'(1) << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_en = 1'b0;
    logic [SW-1:0] cfg_skip = '0;
    logic          cnt_clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_flip;
    logic          mask_en;
    logic [DW-1:0] mask = '0;
    logic [CW-1:0] flip_cnt;
    logic [CW-1:0] beat_cnt;
    logic [1:0]    state;

    always #5 clk = ~clk;

    ber_fault_inject #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW),
        .SKIP_WIDTH(SW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_en_i   (cfg_en),
        .cfg_skip_i (cfg_skip),
        .cnt_clear_i(cnt_clear),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_flip_o (out_flip),
        .mask_en_o  (mask_en),
        .mask_i     (mask),
        .flip_cnt_o (flip_cnt),
        .beat_cnt_o (beat_cnt),
        .state_o    (state)
    );

    int     n_checks = 0;
    int     n_fail = 0;

    // Reference model
    bit     m_en = 1'b0;
    int     m_skip = 0;
    int     m_nacc = 0;
    longint m_flip = 0;
    longint m_beat = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_state();
        if (!m_en) return 0;
        return (m_nacc >= m_skip) ? 2 : 1;
    endfunction

    function automatic bit model_inj();
        return m_en && (m_nacc >= m_skip);
    endfunction

    task automatic model_accept(input logic [63:0] m, input bit clr, output logic [63:0] am);
        bit inj;
        inj = model_inj();
        am = inj ? m : 64'h0;
        if (m_en) m_nacc++;
        if (clr) begin
            m_flip = 0;
            m_beat = 0;
        end else if (inj) begin
            m_flip += $countones(am);
            if (m_flip > CMAX) m_flip = CMAX;
            if (am != 0) m_beat++;
            if (m_beat > CMAX) m_beat = CMAX;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_flip_cnt"}, 64'(flip_cnt), 64'(m_flip));
        check({tag, "_beat_cnt"}, 64'(beat_cnt), 64'(m_beat));
    endtask

    // One beat through an unstalled pipeline, called 1 time unit after a rising edge.
    task automatic send_beat(input logic [63:0] d, input logic [63:0] m, input bit clr);
        logic [63:0] am;
        bit          inj;
        inj       = model_inj();
        in_valid  = 1'b1;
        in_data   = d;
        mask      = m;
        cnt_clear = clr;
        #1;
        check("in_ready", 64'(in_ready), 64'(1));
        check("mask_en", 64'(mask_en), 64'(inj));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        cnt_clear = 1'b0;
        model_accept(m, clr, am);
        check("out_valid", 64'(out_valid), 64'(1));
        check("out_data", out_data, d ^ am);
        check("out_flip", 64'(out_flip), 64'(am != 0));
        check("state", 64'(state), 64'(exp_state()));
        check_counters("beat");
    endtask

    task automatic enable(input int s);
        cfg_en   = 1'b1;
        cfg_skip = SW'(s);
        tick();
        m_en   = 1'b1;
        m_skip = s;
        m_nacc = 0;
        check("enable_state", 64'(state), 64'(exp_state()));
    endtask

    task automatic disable_inj();
        cfg_en = 1'b0;
        tick();
        m_en = 1'b0;
        check("disable_state", 64'(state), 64'(0));
    endtask

    task automatic clear_counters();
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        m_flip = 0;
        m_beat = 0;
        check_counters("clear");
    endtask

    initial begin
        logic [63:0] am;
        logic [63:0] d1;
        logic [63:0] d2;
        logic [63:0] m1;
        logic [63:0] m2;
        logic [63:0] rd;
        logic [63:0] rm;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", out_data, 64'h0);
        check("rst_out_flip", 64'(out_flip), 64'(0));
        check("rst_state", 64'(state), 64'(0));
        check("rst_mask_en", 64'(mask_en), 64'(0));
        check_counters("rst");
        rst = 1'b0;
        tick();

        // Disabled: all-ones mask must not reach data
        send_beat(64'h0123_4567_89AB_CDEF, '1, 1'b0);
        check("off_passthru", out_data, 64'h0123_4567_89AB_CDEF);

        // Immediate injection
        enable(0);
        send_beat(64'h0, 64'hFF, 1'b0);
        check("on_beat0", out_data, 64'hFF);
        send_beat('1, 64'hFF, 1'b0);
        check("on_beat1", out_data, 64'hFFFF_FFFF_FFFF_FF00);
        check("on_flip16", 64'(flip_cnt), 64'd16);
        check("on_beat2", 64'(beat_cnt), 64'd2);
        disable_inj();

        // Warm-up of three clean beats
        clear_counters();
        enable(3);
        for (int i = 0; i < 5; i++) send_beat(64'h0, 64'h1, 1'b0);
        check("warm_beat_cnt", 64'(beat_cnt), 64'd2);
        disable_inj();

        // Back-pressure: held beat stable, no accept, no generator advance
        enable(0);
        d1 = 64'hA5A5_0000_FFFF_1234;
        m1 = 64'h0000_0000_0000_0F0F;
        d2 = 64'h1111_2222_3333_4444;
        m2 = 64'h8000_0000_0000_0001;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = d1;
        mask      = m1;
        #1;
        check("stall_first_mask_en", 64'(mask_en), 64'(1));
        tick();
        model_accept(m1, 1'b0, am);
        in_data = d2;
        mask    = m2;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_mask_en", 64'(mask_en), 64'(0));
            check("stall_out_valid", 64'(out_valid), 64'(1));
            check("stall_out_data", out_data, d1 ^ m1);
            check("stall_out_flip", 64'(out_flip), 64'(1));
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 64'(in_ready), 64'(1));
        check("release_mask_en", 64'(mask_en), 64'(1));
        tick();
        in_valid = 1'b0;
        model_accept(m2, 1'b0, am);
        check("release_out_data", out_data, d2 ^ m2);
        check_counters("release");
        tick();
        check("release_drain", 64'(out_valid), 64'(0));
        disable_inj();

        // Flip-counter saturation, then clear beating an injecting accept
        clear_counters();
        enable(0);
        for (int i = 0; i < 3; i++) send_beat(64'h0, '1, 1'b0);
        send_beat(64'h0, 64'h1FFF_FFFF_FFFF_FFFF, 1'b0);
        check("sat_preload", 64'(flip_cnt), 64'(CMAX - 2));
        send_beat(64'h0, 64'hF, 1'b0);
        check("sat_flip_max", 64'(flip_cnt), 64'(CMAX));
        send_beat(64'h0, 64'hF, 1'b1);
        check("clr_wins_flip", 64'(flip_cnt), 64'd0);
        check("clr_wins_beat", 64'(beat_cnt), 64'd0);

        // Beat-counter saturation
        for (int i = 0; i < 260; i++) begin
            rm = {$urandom, $urandom} | 64'h1;
            send_beat({$urandom, $urandom}, rm, 1'b0);
        end
        check("sat_beat_max", 64'(beat_cnt), 64'(CMAX));
        disable_inj();

        // Randomised enable/skip/data/mask/clear
        clear_counters();
        for (int r = 0; r < 6; r++) begin
            enable(int'($urandom_range(0, 4)));
            for (int b = 0; b < int'($urandom_range(3, 10)); b++) begin
                rd = {$urandom, $urandom};
                rm = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
                send_beat(rd, rm, $urandom_range(0, 15) == 0);
            end
            disable_inj();
            send_beat({$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
        end

        // Reset drops a stalled beat and returns everything to idle
        enable(0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'hDEAD_BEEF_0000_0001;
        mask      = 64'h3;
        tick();
        model_accept(64'h3, 1'b0, am);
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        check_counters("pre_rst");
        rst = 1'b1;
        #1;
        check("in_rst_mask_en", 64'(mask_en), 64'(0));
        check("in_rst_in_ready", 64'(in_ready), 64'(0));
        tick();
        check("post_rst_valid", 64'(out_valid), 64'(0));
        check("post_rst_state", 64'(state), 64'(0));
        check("post_rst_data", out_data, 64'h0);
        check("post_rst_flip", 64'(out_flip), 64'(0));
        m_en   = 1'b0;
        m_flip = 0;
        m_beat = 0;
        check_counters("post_rst");
        rst       = 1'b0;
        cfg_en    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("idle_state", 64'(state), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
